// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the memory arbiter: FSM state encoding and
// requester index constants.
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    // Requester indices into req/we/ack
    localparam logic REQ_CPU = 1'b0;
    localparam logic REQ_LDR = 1'b1;

endpackage : mem_arbiter_pkg

// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter in front of a single synchronous RAM.
// One access at a time: IDLE picks and latches a winner, ACCESS strobes
// the RAM for one cycle, RESP acks the owner and returns read data.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [1:0]        req,
    input  logic [1:0]        we,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    input  logic              load_lock,
    output logic [1:0]        ack,
    output logic [DATA_W-1:0] rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    state_t              state_q, state_d;
    logic                owner_q, owner_d;
    logic                last_grant_q, last_grant_d;
    logic                rd_q, rd_d;
    logic [1:0]          ack_q, ack_d;
    logic                mem_en_q, mem_en_d;
    logic                mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic [1:0]          elig;
    logic                win;

    // Next-state logic: eligibility, round-robin pick, request latch and sequencing
    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        rd_d         = rd_q;
        ack_d        = 2'b00;
        mem_en_d     = 1'b0;
        mem_we_d     = mem_we_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        rdata_d      = rdata_q;

        // The CPU is locked out while the loader owns the program image
        elig = {req[REQ_LDR], req[REQ_CPU] & ~load_lock};
        // On contention, favour whoever did not win last time
        win  = (elig == 2'b11) ? ~last_grant_q : elig[REQ_LDR];

        case (state_q)
            IDLE: begin
                if (elig != 2'b00) begin
                    state_d      = ACCESS;
                    owner_d      = win;
                    last_grant_d = win;
                    rd_d         = ~we[win];
                    mem_en_d     = 1'b1;
                    mem_we_d     = we[win];
                    mem_addr_d   = win ? addr1 : addr0;
                    mem_wdata_d  = win ? wdata1 : wdata0;
                end
            end
            ACCESS: begin
                state_d        = RESP;
                ack_d[owner_q] = 1'b1;
            end
            RESP: begin
                if (rd_q) begin
                    rdata_d = mem_rdata;
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers; reset drops any access in flight
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            owner_q      <= REQ_CPU;
            last_grant_q <= REQ_LDR;
            rd_q         <= 1'b0;
            ack_q        <= 2'b00;
            mem_en_q     <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            rdata_q      <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
            rd_q         <= rd_d;
            ack_q        <= ack_d;
            mem_en_q     <= mem_en_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            rdata_q      <= rdata_d;
        end
    end

    assign ack       = ack_q;
    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign busy      = (state_q != IDLE);
    // RAM data only arrives in the ack cycle, so it is passed straight
    // through then and held in rdata_q afterwards.
    assign rdata     = (state_q == RESP && rd_q) ? mem_rdata : rdata_q;

endmodule : mem_arbiter

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter with a behavioural RAM and a
// transaction-level reference model (round-robin winner, memory image).
module tb_mem_arbiter;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] req = 2'b00;
    logic [1:0] we = 2'b00;
    logic [7:0] addr0 = 8'h00, addr1 = 8'h00;
    logic [7:0] wdata0 = 8'h00, wdata1 = 8'h00;
    logic       load_lock = 1'b0;
    logic [1:0] ack;
    logic [7:0] rdata;
    logic       mem_en, mem_we;
    logic [7:0] mem_addr, mem_wdata;
    logic [7:0] mem_rdata = 8'h00;
    logic       busy;

    int n_cmp = 0;
    int n_err = 0;

    logic [7:0] ram [256];
    bit         ram_init = 1'b0;
    logic [7:0] ref_mem [256];
    int         ref_last;
    logic [7:0] last_rd;

    mem_arbiter #(.ADDR_W(8), .DATA_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .we(we),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .load_lock(load_lock), .ack(ack), .rdata(rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] init_val(input int i);
        logic [7:0] v;
        v = 8'((i * 37 + 11) & 255);
        if (i == 16) v = 8'hA5;
        return v;
    endfunction

    // Synchronous RAM: read data appears the cycle after the strobe
    always @(posedge clk) begin
        if (!ram_init) begin
            for (int i = 0; i < 256; i++) ram[i] <= init_val(i);
            ram_init <= 1'b1;
        end else if (mem_en) begin
            if (mem_we) ram[mem_addr] <= mem_wdata;
            else        mem_rdata <= ram[mem_addr];
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Round-robin rule: loader always eligible, CPU only when unlocked;
    // on contention the one not granted last wins. -1 means no grant.
    function automatic int pick(input logic [1:0] r, input logic lk, input int last);
        bit e0, e1;
        e0 = r[0] && !lk;
        e1 = r[1];
        if (e0 && e1) return 1 - last;
        if (e1) return 1;
        if (e0) return 0;
        return -1;
    endfunction

    task automatic do_reset();
        rst_n = 1'b0;
        req = 2'b00;
        load_lock = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        ref_last = 1;
        last_rd = 8'h00;
    endtask

    // One complete transaction starting in an IDLE cycle, ending in the next IDLE cycle
    task automatic do_txn(input string tag, input logic [1:0] r, input logic [1:0] w,
                          input logic [7:0] a0, input logic [7:0] a1,
                          input logic [7:0] d0, input logic [7:0] d1, input logic lk);
        int win;
        logic       e_we;
        logic [7:0] e_a, e_d;
        req = r; we = w; addr0 = a0; addr1 = a1; wdata0 = d0; wdata1 = d1; load_lock = lk;
        win = pick(r, lk, ref_last);
        step();
        if (win < 0) begin
            chk({tag, ".noreq_en"}, mem_en, 0);
            chk({tag, ".noreq_ack"}, ack, 0);
            chk({tag, ".noreq_busy"}, busy, 0);
            req = 2'b00;
            load_lock = 1'b0;
            return;
        end
        e_we = w[win];
        e_a  = (win == 1) ? a1 : a0;
        e_d  = (win == 1) ? d1 : d0;
        chk({tag, ".en"}, mem_en, 1);
        chk({tag, ".we"}, mem_we, e_we);
        chk({tag, ".addr"}, mem_addr, e_a);
        if (e_we) chk({tag, ".wdata"}, mem_wdata, e_d);
        chk({tag, ".ack_early"}, ack, 0);
        chk({tag, ".busy_acc"}, busy, 1);
        // Inputs wander after the latch; the access in flight must not notice
        addr0 = 8'($urandom); addr1 = 8'($urandom);
        wdata0 = 8'($urandom); wdata1 = 8'($urandom);
        we = 2'($urandom); load_lock = 1'($urandom);
        step();
        chk({tag, ".ack"}, ack, 32'(1) << win);
        chk({tag, ".en_resp"}, mem_en, 0);
        chk({tag, ".busy_resp"}, busy, 1);
        if (e_we) begin
            ref_mem[e_a] = e_d;
        end else begin
            chk({tag, ".rdata"}, rdata, ref_mem[e_a]);
            last_rd = ref_mem[e_a];
        end
        ref_last = win;
        req = 2'b00;
        load_lock = 1'b0;
        step();
        chk({tag, ".ack_idle"}, ack, 0);
        chk({tag, ".busy_idle"}, busy, 0);
        chk({tag, ".en_idle"}, mem_en, 0);
        chk({tag, ".rdata_hold"}, rdata, last_rd);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) ref_mem[i] = init_val(i);
        ref_last = 1;
        last_rd = 8'h00;

        // Reset values
        do_reset();
        chk("rst.ack", ack, 0);
        chk("rst.en", mem_en, 0);
        chk("rst.we", mem_we, 0);
        chk("rst.addr", mem_addr, 0);
        chk("rst.wdata", mem_wdata, 0);
        chk("rst.rdata", rdata, 0);
        chk("rst.busy", busy, 0);

        // CPU read of 0x10, loader write of 0x20, read-back
        do_txn("cpu_rd10", 2'b01, 2'b00, 8'h10, 8'h00, 8'h00, 8'h00, 1'b0);
        chk("cpu_rd10.const", last_rd, 8'hA5);
        do_txn("ldr_wr20", 2'b10, 2'b10, 8'h00, 8'h20, 8'h00, 8'h3C, 1'b0);
        do_txn("rdback20", 2'b01, 2'b00, 8'h20, 8'h00, 8'h00, 8'h00, 1'b0);
        chk("rdback20.const", last_rd, 8'h3C);

        // Continuous contention after reset: CPU, loader, CPU, loader
        do_reset();
        req = 2'b11; we = 2'b00; addr0 = 8'h31; addr1 = 8'h32; load_lock = 1'b0;
        for (int j = 1; j <= 12; j++) begin
            logic [1:0] e_ack;
            int slot;
            step();
            slot = (j - 1) / 3;
            e_ack = 2'b00;
            if ((j % 3) == 2 && j <= 11) e_ack = (slot % 2 == 0) ? 2'b01 : 2'b10;
            chk($sformatf("rr.ack%0d", j), ack, e_ack);
            chk($sformatf("rr.en%0d", j), mem_en, ((j % 3) == 1 && j <= 10) ? 1 : 0);
            if ((j % 3) == 1 && j <= 10)
                chk($sformatf("rr.addr%0d", j), mem_addr, (slot % 2 == 0) ? 8'h31 : 8'h32);
        end
        ref_last = 1;

        // Lock holds the CPU off; once released the CPU wins the next IDLE
        load_lock = 1'b1;
        for (int k = 1; k <= 9; k++) begin
            logic [1:0] e_ack;
            step();
            e_ack = 2'b00;
            if (k == 2 || k == 5) e_ack = 2'b10;
            if (k == 8) e_ack = 2'b01;
            chk($sformatf("lock.ack%0d", k), ack, e_ack);
            if (k == 7) chk("lock.cpu_addr", mem_addr, 8'h31);
            if (k == 6) load_lock = 1'b0;
            if (k == 8) req = 2'b00;
        end
        ref_last = 0;
        last_rd = ref_mem[8'h31];
        chk("lock.rdata_hold", rdata, last_rd);

        // Randomised transactions against the reference model
        for (int t = 0; t < 60; t++) begin
            do_txn($sformatf("rnd%0d", t), 2'($urandom), 2'($urandom),
                   8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom),
                   1'($urandom_range(0, 3) == 0));
        end

        // Reset during a write ACCESS: no ack, back to IDLE
        req = 2'b10; we = 2'b10; addr1 = 8'h40; wdata1 = 8'h99;
        step();
        chk("rstacc.en", mem_en, 1);
        req = 2'b00;
        rst_n = 1'b0;
        step();
        ref_mem[8'h40] = 8'h99;
        rst_n = 1'b1;
        ref_last = 1;
        last_rd = 8'h00;
        chk("rstacc.ack", ack, 0);
        chk("rstacc.busy", busy, 0);
        chk("rstacc.en0", mem_en, 0);
        step();
        chk("rstacc.ack_late", ack, 0);
        chk("rstacc.rdata", rdata, 0);

        // Reset on the sampling edge: the write never strobes
        req = 2'b10; we = 2'b10; addr1 = 8'h50; wdata1 = 8'hEE;
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        req = 2'b00;
        chk("rstidle.en", mem_en, 0);
        chk("rstidle.busy", busy, 0);
        step();
        chk("rstidle.ack", ack, 0);
        do_txn("rd50", 2'b01, 2'b00, 8'h50, 8'h00, 8'h00, 8'h00, 1'b0);
        chk("rd50.const", last_rd, init_val(8'h50));
        do_txn("rd40", 2'b01, 2'b00, 8'h40, 8'h00, 8'h00, 8'h00, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_mem_arbiter

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 8, memory address width in bits.
REQ-002 Parameter DATA_W, default 8, memory data width in bits.
REQ-003 clk  input  1  single system clock; all state changes on rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 req  input  2  access request per requester; bit 0 = CPU control unit, bit 1 = program loader.
REQ-006 we  input  2  per-requester write flag (1 = write, 0 = read), valid while req bit high.
REQ-007 addr0, addr1  input  ADDR_W each  per-requester address, held stable while req bit high.
REQ-008 wdata0, wdata1  input  DATA_W each  per-requester write data, held stable while req bit high.
REQ-009 load_lock  input  1  when high, CPU (bit 0) requests are not granted.
REQ-010 ack  output  2  one-cycle completion pulse per requester.
REQ-011 rdata  output  DATA_W  read data, valid only in the cycle ack is high for a read.
REQ-012 mem_en, mem_we  output  1 each  memory strobe and write enable to the synchronous RAM.
REQ-013 mem_addr  output  ADDR_W; mem_wdata  output  DATA_W  memory address and write data.
REQ-014 mem_rdata  input  DATA_W  RAM read data, valid the cycle after the mem_en cycle.
REQ-015 busy  output  1  high whenever the FSM is not in IDLE.

Function
REQ-016 The FSM SHALL have three states: IDLE, ACCESS, RESP; all outputs registered.
REQ-017 In IDLE with no eligible request, the FSM SHALL stay in IDLE with mem_en=0 and ack=0.
REQ-018 In IDLE with an eligible request, the block SHALL latch the owner, addr, we and wdata of the winner and move to ACCESS.
REQ-019 Eligible set: req[1]; req[0] only when load_lock=0.
REQ-020 With both eligible, the winner SHALL be the requester not granted last (round-robin); last_grant updates on every grant.
REQ-021 In ACCESS, mem_en SHALL be 1 for exactly one cycle, with mem_we, mem_addr, mem_wdata from the latched request; next state RESP.
REQ-022 In RESP, ack[owner] SHALL pulse for one cycle and, for a read, rdata SHALL equal mem_rdata; next state IDLE.
REQ-023 Latency: request sampled in IDLE at cycle N -> mem_en high in N+1 -> ack high in N+2; peak throughput one access per 3 cycles.
REQ-024 Requesters SHALL drop req within the cycle after ack; req still high in the following IDLE cycle is a new request.
REQ-025 Requester inputs changing after latch (ACCESS/RESP) SHALL NOT affect the access in flight.
REQ-026 load_lock rising during a CPU access SHALL NOT abort it; the access completes and is acked.
REQ-027 ack SHALL never have both bits high; mem_en SHALL be 0 outside ACCESS.
REQ-028 rdata SHALL hold its last value outside RESP; it is not valid without ack.

Reset
REQ-029 With rst_n=0 at a rising edge: state=IDLE, ack=0, mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0, rdata=0, busy=0, last_grant=1 (CPU wins first contention).
REQ-030 Reset mid-operation SHALL discard the access in flight with no ack issued; a write not yet strobed SHALL NOT reach memory.

Structure
REQ-031 State encodings (IDLE, ACCESS, RESP) and the requester index constants (REQ_CPU=0, REQ_LDR=1) SHALL live in the shared processor package.
REQ-032 The block SHALL be a single module with no sub-modules; the round-robin picker stays inline.

Verification
REQ-033 CPU read of addr 0x10 (RAM 0x10=0xA5): req=01, we=00 at N -> mem_en=1, mem_we=0, mem_addr=0x10 at N+1; ack=01, rdata=0xA5 at N+2.
REQ-034 Loader write addr 0x20 data 0x3C -> mem_en=1, mem_we=1, mem_addr=0x20, mem_wdata=0x3C at N+1; ack=10 at N+2; RAM 0x20 reads back 0x3C.
REQ-035 After reset, both request continuously -> grants CPU, loader, CPU, loader; acks at N+2, N+5, N+8, N+11.
REQ-036 load_lock=1 with req=11 -> only loader granted; CPU ack=0 until lock drops, then CPU granted in the next IDLE.
REQ-037 rst_n=0 during ACCESS of a write -> no ack; after release state=IDLE, busy=0, memory unchanged if reset precedes the strobe edge.
